// File: rtl/nerv_run_ctrl_if.sv
// Command and stop-event handshakes between the GDB stub and run control.
// master = stub side, slave = nerv_run_ctrl.
interface nerv_run_ctrl_if #(
    parameter int XLEN = 32,
    parameter int BNUM = 4,
    localparam int BW = (BNUM > 1) ? $clog2(BNUM) : 1
);
    logic            cmd_vld;
    logic            cmd_rdy;
    logic [1:0]      cmd_op;
    logic            stop_vld;
    logic            stop_rdy;
    logic [1:0]      stop_reason;
    logic [XLEN-1:0] stop_pc;
    logic [BW-1:0]   stop_bpi;

    modport master (
        output cmd_vld, cmd_op, stop_rdy,
        input  cmd_rdy, stop_vld, stop_reason, stop_pc, stop_bpi
    );

    modport slave (
        input  cmd_vld, cmd_op, stop_rdy,
        output cmd_rdy, stop_vld, stop_reason, stop_pc, stop_bpi
    );
endinterface

// File: rtl/nerv_run_ctrl.sv
// NERV run-control sequencer: halt/continue/step/reset, hw breakpoints.
// Optional data watchpoint enabled by defining NERV_RUN_CTRL_WATCH_EN.
module nerv_run_ctrl #(
    parameter int XLEN = 32,
    parameter int BNUM = 4,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int RST_CYC = 4,
    localparam int BW = (BNUM > 1) ? $clog2(BNUM) : 1
) (
    input  logic            clk,
    input  logic            rst,
    nerv_run_ctrl_if.slave  bus,
    input  logic            bp_wen,
    input  logic [BW-1:0]   bp_idx,
    input  logic [XLEN-1:0] bp_addr,
    input  logic            bp_ena,
    output logic            cpu_stall,
    output logic            cpu_rst,
    input  logic            ret_vld,
    input  logic [XLEN-1:0] ret_npc
`ifdef NERV_RUN_CTRL_WATCH_EN
    ,
    input  logic            mem_vld,
    input  logic            mem_we,
    input  logic [XLEN-1:0] mem_addr,
    input  logic            wp_wen,
    input  logic [XLEN-1:0] wp_addr,
    input  logic            wp_ena,
    input  logic            wp_wonly
`endif
);

    localparam int CW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [XLEN-1:0] AMASK = {{(XLEN-2){1'b1}}, 2'b00};

    localparam logic [1:0] OP_HALT = 2'd0;
    localparam logic [1:0] OP_CONT = 2'd1;
    localparam logic [1:0] OP_STEP = 2'd2;
    localparam logic [1:0] OP_RST  = 2'd3;

    localparam logic [1:0] R_HALT  = 2'd0;
    localparam logic [1:0] R_STEP  = 2'd1;
    localparam logic [1:0] R_BREAK = 2'd2;
    localparam logic [1:0] R_WATCH = 2'd3;

    typedef enum logic [2:0] {
        S_HALTED,
        S_RUN,
        S_STEP,
        S_CRST,
        S_REPORT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0]   cnt;
    logic            stop_vld_q;
    logic [1:0]      stop_rsn_q;
    logic [XLEN-1:0] stop_pc_q;
    logic [BW-1:0]   stop_bpi_q;

    logic [XLEN-1:0] bp_addr_q [BNUM];
    logic [BNUM-1:0] bp_ena_q;

    logic            bp_hit;
    logic [BW-1:0]   bp_sel;
    logic            wp_hit;
    logic            running;
    logic            halt_acc;
    logic            go;
    logic [1:0]      rsn;
    logic [XLEN-1:0] npc;
    logic [BW-1:0]   bsel;

    assign running  = (state == S_RUN) || (state == S_STEP);
    assign halt_acc = bus.cmd_vld && bus.cmd_op == OP_HALT;

    assign bus.cmd_rdy     = (state == S_HALTED) ||
                             (running && bus.cmd_op == OP_HALT);
    assign bus.stop_vld    = stop_vld_q;
    assign bus.stop_reason = stop_rsn_q;
    assign bus.stop_pc     = stop_pc_q;
    assign bus.stop_bpi    = stop_bpi_q;

    // Scan high to low so the lowest matching index is the one kept.
    always_comb begin
        bp_hit = 1'b0;
        bp_sel = '0;
        for (int i = BNUM - 1; i >= 0; i--) begin
            if (ret_vld && bp_ena_q[i] &&
                (((ret_npc ^ bp_addr_q[i]) & AMASK) == '0)) begin
                bp_hit = 1'b1;
                bp_sel = BW'(i);
            end
        end
    end

`ifdef NERV_RUN_CTRL_WATCH_EN
    logic [XLEN-1:0] wp_addr_q;
    logic            wp_ena_q;
    logic            wp_wonly_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_addr_q  <= '0;
            wp_ena_q   <= 1'b0;
            wp_wonly_q <= 1'b0;
        end else if (wp_wen) begin
            wp_addr_q  <= wp_addr;
            wp_ena_q   <= wp_ena;
            wp_wonly_q <= wp_wonly;
        end
    end

    assign wp_hit = ret_vld && mem_vld && wp_ena_q &&
                    (((mem_addr ^ wp_addr_q) & AMASK) == '0) &&
                    (!wp_wonly_q || mem_we);
`else
    assign wp_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bp_ena_q <= '0;
            for (int i = 0; i < BNUM; i++) bp_addr_q[i] <= '0;
        end else if (bp_wen && (int'(bp_idx) < BNUM)) begin
            bp_addr_q[bp_idx] <= bp_addr;
            bp_ena_q[bp_idx]  <= bp_ena;
        end
    end

    // Stop event: priority watch > break > step > halt request.
    always_comb begin
        go   = 1'b0;
        rsn  = R_HALT;
        npc  = pc_q;
        bsel = '0;
        unique case (state)
            S_HALTED: go = halt_acc;
            S_RUN, S_STEP: begin
                if (wp_hit) begin
                    go  = 1'b1;
                    rsn = R_WATCH;
                    npc = ret_npc;
                end else if (bp_hit) begin
                    go   = 1'b1;
                    rsn  = R_BREAK;
                    npc  = ret_npc;
                    bsel = bp_sel;
                end else if (state == S_STEP && ret_vld) begin
                    go  = 1'b1;
                    rsn = R_STEP;
                    npc = ret_npc;
                end else if (halt_acc) begin
                    go  = 1'b1;
                    npc = ret_vld ? ret_npc : pc_q;
                end
            end
            S_CRST: begin
                go  = (cnt == '0);
                npc = RESET_ADDR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_HALTED;
            cpu_stall  <= 1'b1;
            cpu_rst    <= 1'b0;
            cnt        <= '0;
            pc_q       <= RESET_ADDR;
            stop_vld_q <= 1'b0;
            stop_rsn_q <= R_HALT;
            stop_pc_q  <= RESET_ADDR;
            stop_bpi_q <= '0;
        end else begin
            if (state == S_CRST) pc_q <= RESET_ADDR;
            else if (ret_vld)    pc_q <= ret_npc;

            if (go) begin
                state      <= S_REPORT;
                cpu_stall  <= 1'b1;
                cpu_rst    <= 1'b0;
                stop_vld_q <= 1'b1;
                stop_rsn_q <= rsn;
                stop_pc_q  <= npc;
                stop_bpi_q <= bsel;
            end else begin
                unique case (state)
                    S_HALTED: begin
                        if (bus.cmd_vld) begin
                            unique case (bus.cmd_op)
                                OP_CONT: begin
                                    state     <= S_RUN;
                                    cpu_stall <= 1'b0;
                                end
                                OP_STEP: begin
                                    state     <= S_STEP;
                                    cpu_stall <= 1'b0;
                                end
                                OP_RST: begin
                                    state   <= S_CRST;
                                    cpu_rst <= 1'b1;
                                    cnt     <= CW'(RST_CYC - 1);
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_CRST: cnt <= cnt - CW'(1);
                    S_REPORT: begin
                        if (bus.stop_rdy) begin
                            state      <= S_HALTED;
                            stop_vld_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nerv_run_ctrl.sv
// Scoreboard bench for nerv_run_ctrl: directed commands and retirements,
// a negedge monitor pops expected stop events on each handshake.
module tb_nerv_run_ctrl;

    typedef struct {
        logic [1:0]  rsn;
        logic [31:0] pc;
        logic [1:0]  bpi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bp_wen = 1'b0;
    logic [1:0]  bp_idx = '0;
    logic [31:0] bp_addr = '0;
    logic        bp_ena = 1'b0;
    logic        cpu_stall;
    logic        cpu_rst;
    logic        ret_vld = 1'b0;
    logic [31:0] ret_npc = '0;
`ifdef NERV_RUN_CTRL_WATCH_EN
    logic        mem_vld = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        wp_wen = 1'b0;
    logic [31:0] wp_addr = '0;
    logic        wp_ena = 1'b0;
    logic        wp_wonly = 1'b0;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sbq[$];

    nerv_run_ctrl_if #(.XLEN(32), .BNUM(4)) bus ();

    nerv_run_ctrl #(
        .XLEN(32), .BNUM(4), .RESET_ADDR(32'h0), .RST_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .bp_wen(bp_wen),
        .bp_idx(bp_idx),
        .bp_addr(bp_addr),
        .bp_ena(bp_ena),
        .cpu_stall(cpu_stall),
        .cpu_rst(cpu_rst),
        .ret_vld(ret_vld),
        .ret_npc(ret_npc)
`ifdef NERV_RUN_CTRL_WATCH_EN
        ,
        .mem_vld(mem_vld),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .wp_wen(wp_wen),
        .wp_addr(wp_addr),
        .wp_ena(wp_ena),
        .wp_wonly(wp_wonly)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] r, input logic [31:0] p,
                        input logic [1:0] b);
        exp_t e;
        e.rsn = r;
        e.pc  = p;
        e.bpi = b;
        sbq.push_back(e);
    endtask

    // Monitor: one pop per accepted stop event.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.stop_vld && bus.stop_rdy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_stop", 32'(bus.stop_reason), 32'hdead);
                end else begin
                    e = sbq.pop_front();
                    chk("stop_reason", 32'(bus.stop_reason), 32'(e.rsn));
                    chk("stop_pc", bus.stop_pc, e.pc);
                    chk("stop_bpi", 32'(bus.stop_bpi), 32'(e.bpi));
                end
            end
        end
    end

    task automatic send_cmd(input logic [1:0] op, input string nm);
        int n = 0;
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = op;
        @(negedge clk);
        while (!bus.cmd_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(bus.cmd_rdy), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_vld = 1'b0;
    endtask

    task automatic wait_sb(input string nm);
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(sbq.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic bp_write(input logic [1:0] i, input logic [31:0] a,
                            input logic e);
        bp_wen  = 1'b1;
        bp_idx  = i;
        bp_addr = a;
        bp_ena  = e;
        @(posedge clk);
        #1;
        bp_wen = 1'b0;
    endtask

    // Core model: retires sequentially while not stalled.
    task automatic run_core(input logic [31:0] start, input int limit,
                            output int n, output logic [31:0] last);
        logic [31:0] p = start;
        n = 0;
        while (!cpu_stall && n < limit) begin
            ret_vld = 1'b1;
            p       = p + 32'd4;
            ret_npc = p;
            n++;
            @(posedge clk);
            #1;
        end
        ret_vld = 1'b0;
        last    = p;
    endtask

    initial begin
        int          n;
        logic [31:0] last;

        bus.cmd_vld  = 1'b0;
        bus.cmd_op   = 2'd0;
        bus.stop_rdy = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(cpu_stall), 32'd1);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        chk("rst_stop_vld", 32'(bus.stop_vld), 32'd0);
        chk("rst_stop_pc", bus.stop_pc, 32'h0);
        chk("rst_reason", 32'(bus.stop_reason), 32'd0);
        chk("rst_cmd_rdy", 32'(bus.cmd_rdy), 32'd1);
        @(posedge clk);
        #1;

        push(2'd0, 32'h0, 2'd0);
        send_cmd(2'd0, "halt_rdy");
        @(negedge clk);
        chk("halt_lat", 32'(bus.stop_vld), 32'd1);
        wait_sb("halt_drain");

        bp_write(2'd2, 32'h0000_0040, 1'b1);
        bp_write(2'd1, 32'h0000_0102, 1'b1);
        bp_write(2'd3, 32'h0000_0100, 1'b1);

        push(2'd2, 32'h40, 2'd2);
        send_cmd(2'd1, "cont_rdy");
        chk("cont_stall", 32'(cpu_stall), 32'd0);
        run_core(32'h0, 100, n, last);
        chk("bp_ret_cnt", 32'(n), 32'd16);
        chk("bp_stall", 32'(cpu_stall), 32'd1);
        wait_sb("bp_drain");

        push(2'd1, 32'h44, 2'd0);
        send_cmd(2'd2, "step_rdy");
        run_core(32'h40, 100, n, last);
        chk("step_ret_cnt", 32'(n), 32'd1);
        wait_sb("step_drain");

        push(2'd2, 32'h100, 2'd1);
        send_cmd(2'd1, "cont2_rdy");
        run_core(32'h44, 200, n, last);
        chk("lowidx_ret_cnt", 32'(n), 32'd47);
        wait_sb("lowidx_drain");

        send_cmd(2'd1, "cont3_rdy");
        run_core(32'h100, 3, n, last);
        bus.stop_rdy = 1'b0;
        push(2'd0, 32'h10c, 2'd0);
        send_cmd(2'd0, "halt_run_rdy");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(bus.stop_vld), 32'd1);
            chk("hold_pc", bus.stop_pc, 32'h10c);
            chk("hold_rsn", 32'(bus.stop_reason), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.stop_rdy = 1'b1;
        wait_sb("hold_drain");
        send_cmd(2'd1, "cont_after_hold");

        bp_write(2'd0, 32'h0000_0118, 1'b1);
        run_core(32'h10c, 2, n, last);
        push(2'd2, 32'h118, 2'd0);
        ret_vld     = 1'b1;
        ret_npc     = 32'h118;
        bus.cmd_vld = 1'b1;
        bus.cmd_op  = 2'd0;
        @(negedge clk);
        chk("halt_hit_rdy", 32'(bus.cmd_rdy), 32'd1);
        @(posedge clk);
        #1;
        ret_vld     = 1'b0;
        bus.cmd_vld = 1'b0;
        wait_sb("halt_hit_drain");

        push(2'd0, 32'h0, 2'd0);
        send_cmd(2'd3, "crst_rdy");
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.stop_vld) break;
            if (cpu_rst) n++;
            chk("crst_stall", 32'(cpu_stall), 32'd1);
        end
        chk("crst_cycles", 32'(n), 32'd4);
        wait_sb("crst_drain");

        send_cmd(2'd1, "cont4_rdy");
        run_core(32'h0, 5, n, last);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_stall", 32'(cpu_stall), 32'd1);
        chk("arst_stop_pc", bus.stop_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send_cmd(2'd1, "cont5_rdy");
        run_core(32'h0, 70, n, last);
        chk("bp_cleared_cnt", 32'(n), 32'd70);
        push(2'd0, 32'h118, 2'd0);
        send_cmd(2'd0, "halt2_rdy");
        wait_sb("arst_drain");

`ifdef NERV_RUN_CTRL_WATCH_EN
        wp_wen   = 1'b1;
        wp_addr  = 32'h100;
        wp_ena   = 1'b1;
        wp_wonly = 1'b1;
        @(posedge clk);
        #1;
        wp_wen = 1'b0;
        bp_write(2'd3, 32'h0000_0308, 1'b1);
        send_cmd(2'd1, "cont_wp_rdy");
        ret_vld  = 1'b1;
        ret_npc  = 32'h11c;
        mem_vld  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = 32'h100;
        @(posedge clk);
        #1;
        chk("wp_load_ign", 32'(cpu_stall), 32'd0);
        push(2'd3, 32'h308, 2'd0);
        ret_npc  = 32'h308;
        mem_we   = 1'b1;
        mem_addr = 32'h102;
        @(posedge clk);
        #1;
        ret_vld = 1'b0;
        mem_vld = 1'b0;
        mem_we  = 1'b0;
        wait_sb("wp_drain");
`endif

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
